// File: rtl/maxpool2d.sv
// ============================================================================
// Module   : maxpool2d
// Brief    : Per-channel 2-D max pooling over an NCHW map held in a
//            synchronous-read memory; results written NCHW. Optional macro
//            MAXPOOL2D_RELU_EN fuses a ReLU into the stored value.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module maxpool2d #(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 4,
    parameter int IN_WIDTH   = 4,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_en,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);

    localparam int c_OUT_H = (IN_HEIGHT - POOL_SIZE) / STRIDE + 1;
    localparam int c_OUT_W = (IN_WIDTH - POOL_SIZE) / STRIDE + 1;

    localparam int c_B_W   = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int c_CH_W  = (CHANNELS > 1)   ? $clog2(CHANNELS)   : 1;
    localparam int c_ROW_W = (c_OUT_H > 1)    ? $clog2(c_OUT_H)    : 1;
    localparam int c_COL_W = (c_OUT_W > 1)    ? $clog2(c_OUT_W)    : 1;
    localparam int c_K_W   = (POOL_SIZE > 1)  ? $clog2(POOL_SIZE)  : 1;

    localparam logic [c_B_W-1:0]   c_B_LAST   = c_B_W'(BATCH_SIZE - 1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(CHANNELS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(c_OUT_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_OUT_W - 1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(POOL_SIZE - 1);

    localparam logic [ADDR_WIDTH-1:0] c_IN_B   = ADDR_WIDTH'(CHANNELS * IN_HEIGHT * IN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_IN_CH  = ADDR_WIDTH'(IN_HEIGHT * IN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_IN_W   = ADDR_WIDTH'(IN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_OUT_B  = ADDR_WIDTH'(CHANNELS * c_OUT_H * c_OUT_W);
    localparam logic [ADDR_WIDTH-1:0] c_OUT_CH = ADDR_WIDTH'(c_OUT_H * c_OUT_W);
    localparam logic [ADDR_WIDTH-1:0] c_OUT_WA = ADDR_WIDTH'(c_OUT_W);
    localparam logic [ADDR_WIDTH-1:0] c_STR    = ADDR_WIDTH'(STRIDE);
    localparam logic [DATA_WIDTH-1:0] c_MAX_INIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_REQ   = 3'd2,
        S_CMP   = 3'd3,
        S_STORE = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_B_W-1:0]      r_b;
    logic [c_CH_W-1:0]     r_ch;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_COL_W-1:0]    r_col;
    logic [c_K_W-1:0]      r_kr;
    logic [c_K_W-1:0]      r_kc;
    logic [DATA_WIDTH-1:0] r_max;

    logic                  w_kc_last, w_kr_last, w_win_done, w_last_out;
    logic [c_K_W-1:0]      w_kr_nxt, w_kc_nxt, w_kr_sel, w_kc_sel;
    logic [ADDR_WIDTH-1:0] w_row_in, w_col_in, w_in_addr, w_out_addr;
    logic [DATA_WIDTH-1:0] w_max_nxt, w_store_data;

    assign w_kc_last  = (r_kc == c_K_LAST);
    assign w_kr_last  = (r_kr == c_K_LAST);
    assign w_win_done = w_kc_last && w_kr_last;
    assign w_kc_nxt   = w_kc_last ? '0 : r_kc + c_K_W'(1);
    assign w_kr_nxt   = w_kc_last ? r_kr + c_K_W'(1) : r_kr;
    assign w_last_out = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST) &&
                        (r_ch == c_CH_LAST) && (r_b == c_B_LAST);

    // The read address is issued one state ahead of the compare, so INIT
    // addresses element (0,0) and CMP addresses the next window element.
    assign w_kr_sel   = (r_state == S_INIT) ? '0 : w_kr_nxt;
    assign w_kc_sel   = (r_state == S_INIT) ? '0 : w_kc_nxt;
    assign w_row_in   = ADDR_WIDTH'(r_row) * c_STR + ADDR_WIDTH'(w_kr_sel);
    assign w_col_in   = ADDR_WIDTH'(r_col) * c_STR + ADDR_WIDTH'(w_kc_sel);
    assign w_in_addr  = ADDR_WIDTH'(r_b) * c_IN_B + ADDR_WIDTH'(r_ch) * c_IN_CH +
                        w_row_in * c_IN_W + w_col_in;
    assign w_out_addr = ADDR_WIDTH'(r_b) * c_OUT_B + ADDR_WIDTH'(r_ch) * c_OUT_CH +
                        ADDR_WIDTH'(r_row) * c_OUT_WA + ADDR_WIDTH'(r_col);

    // Strictly-greater replace: ties keep the earlier sample.
    assign w_max_nxt = ($signed(input_data) > $signed(r_max)) ? input_data : r_max;

    always_comb begin
        w_store_data = w_max_nxt;
`ifdef MAXPOOL2D_RELU_EN
        if (w_max_nxt[DATA_WIDTH-1])
            w_store_data = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_b         <= '0;
            r_ch        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_max       <= '0;
            done        <= 1'b0;
            valid       <= 1'b0;
            input_addr  <= '0;
            input_en    <= 1'b0;
            output_addr <= '0;
            output_data <= '0;
            output_we   <= 1'b0;
            output_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b     <= '0;
                        r_ch    <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_kr       <= '0;
                    r_kc       <= '0;
                    r_max      <= c_MAX_INIT;
                    input_addr <= w_in_addr;
                    input_en   <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    input_en <= 1'b0;
                    r_state  <= S_CMP;
                end
                S_CMP: begin
                    r_max <= w_max_nxt;
                    if (w_win_done) begin
                        output_addr <= w_out_addr;
                        output_data <= w_store_data;
                        output_we   <= 1'b1;
                        output_en   <= 1'b1;
                        r_state     <= S_STORE;
                    end else begin
                        r_kr       <= w_kr_nxt;
                        r_kc       <= w_kc_nxt;
                        input_addr <= w_in_addr;
                        input_en   <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_STORE: begin
                    output_we <= 1'b0;
                    output_en <= 1'b0;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        if (r_row == c_ROW_LAST) begin
                            r_row <= '0;
                            if (r_ch == c_CH_LAST) begin
                                r_ch <= '0;
                                r_b  <= r_b + c_B_W'(1);
                            end else begin
                                r_ch <= r_ch + c_CH_W'(1);
                            end
                        end else begin
                            r_row <= r_row + c_ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + c_COL_W'(1);
                    end
                    if (w_last_out) begin
                        done    <= 1'b1;
                        valid   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_INIT;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        valid   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
